// File: rtl/timer_dev.sv
// Memory-mapped countdown timer on the data-store bus: CTRL/PRESET/COUNT registers,
// one-shot or auto-reload countdown, level interrupt on terminal count.
module timer_dev #(
    parameter int          CNT_W      = 32,
    parameter logic [31:0] RST_PRESET = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [3:0]  be,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    localparam logic [1:0] MODE_RELOAD = 2'd1;

    logic [1:0]       state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             ctrl_wr;
    logic             preset_wr;
    logic [31:0]      preset_ext;
    logic [31:0]      count_ext;
    logic [31:0]      preset_merged;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  ben
    );
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = ben[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

    assign preset_ext    = 32'(preset_q);
    assign count_ext     = 32'(count_q);
    assign preset_merged = byte_merge(preset_ext, din, be);

    // Only byte lane 0 of CTRL is writable; COUNT and the reserved word ignore writes.
    assign ctrl_wr   = we && (addr == A_CTRL) && be[0];
    assign preset_wr = we && (addr == A_PRESET);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        en_d     = ctrl_wr ? din[0]   : en_q;
        mode_d   = ctrl_wr ? din[2:1] : mode_q;
        im_d     = ctrl_wr ? din[3]   : im_q;
        pend_d   = ctrl_wr ? 1'b0     : pend_q;
        preset_d = preset_wr ? preset_merged[CNT_W-1:0] : preset_q;

        // The FSM acts on register values from before this edge; the INT
        // assignments below come last so a terminal-count event beats a
        // simultaneous CTRL write (PEND set wins, one-shot EN clear wins).
        case (state_q)
            S_IDLE: begin
                if (en_q) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (en_q) begin
                    count_d = preset_q;
                    state_d = S_CNT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (count_q == '0) begin
                    state_d = S_INT;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            S_INT: begin
                pend_d = 1'b1;
                if (mode_q == MODE_RELOAD) begin
                    state_d = S_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            mode_q   <= 2'd0;
            im_q     <= 1'b0;
            pend_q   <= 1'b0;
            preset_q <= RST_PRESET[CNT_W-1:0];
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            pend_q   <= pend_d;
            preset_q <= preset_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            A_CTRL:   dout = {27'd0, pend_q, im_q, mode_q, en_q};
            A_PRESET: dout = preset_ext;
            A_COUNT:  dout = count_ext;
            default:  dout = 32'd0;
        endcase
    end

    assign irq = pend_q & im_q;

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: register-map vector table followed by hand-written
// multi-cycle sequences, all checked through an expectation queue.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [3:0]  be;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        logic        irq;
        string       nm;
    } exp_t;

    vec_t tbl [10];
    exp_t sbq [$];

    timer_dev #(.CNT_W(32), .RST_PRESET(32'd0)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .be   (be),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Drive one bus cycle, queue its expectation, then compare after the edge.
    task automatic step(input logic w, input logic [1:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] ed, input logic ei,
                        input string nm);
        exp_t e;
        @(negedge clk);
        we = w; addr = a; be = b; din = d;
        e.dout = ed; e.irq = ei; e.nm = nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty got %h expected an entry", nm, dout);
        end else begin
            e = sbq.pop_front();
            check32({e.nm, " dout"}, dout, e.dout);
            check32({e.nm, " irq"}, {31'd0, irq}, {31'd0, e.irq});
        end
    endtask

    initial begin
        int exp_cnt;
        logic wr, hi;

        tbl[0] = '{1'b0, 2'd0, 4'h0, 32'h0,        32'h0,        1'b0};
        tbl[1] = '{1'b0, 2'd1, 4'h0, 32'h0,        32'h0,        1'b0};
        tbl[2] = '{1'b0, 2'd2, 4'h0, 32'h0,        32'h0,        1'b0};
        tbl[3] = '{1'b0, 2'd3, 4'h0, 32'h0,        32'h0,        1'b0};
        tbl[4] = '{1'b1, 2'd1, 4'b0101, 32'h12345678, 32'h00340078, 1'b0};
        tbl[5] = '{1'b1, 2'd2, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b0};
        tbl[6] = '{1'b1, 2'd3, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b0};
        tbl[7] = '{1'b0, 2'd1, 4'h0, 32'h0,        32'h00340078, 1'b0};
        tbl[8] = '{1'b1, 2'd0, 4'b1110, 32'h0000000F, 32'h0,     1'b0};
        tbl[9] = '{1'b1, 2'd1, 4'hF, 32'd5,        32'd5,        1'b0};

        rst = 1'b0; we = 1'b0; addr = 2'd0; be = 4'h0; din = 32'd0;
        step(0, 2'd0, 4'h0, 0, 32'h0, 0, "rst_hold0");
        step(0, 2'd1, 4'h0, 0, 32'h0, 0, "rst_hold1");
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].din,
                 tbl[i].exp_dout, tbl[i].exp_irq, $sformatf("tbl%0d", i));
        end

        // One-shot, PRESET=5: irq rises 9 edges after the enabling write.
        step(1, 2'd0, 4'hF, 32'h9, 32'h9, 0, "os_wr");
        for (int k = 1; k <= 9; k++) begin
            exp_cnt = (k < 2) ? 0 : ((k <= 7) ? 7 - k : 0);
            step(0, 2'd2, 4'h0, 0, 32'(exp_cnt), (k >= 9), $sformatf("os_cnt%0d", k));
        end
        step(0, 2'd0, 4'h0, 0, 32'h18, 1, "os_ctrl");
        step(0, 2'd2, 4'h0, 0, 32'h0, 1, "os_hold");
        step(1, 2'd0, 4'hF, 32'h8, 32'h8, 0, "os_clr");

        // Auto-reload, PRESET=2: PEND every 5 edges; write at k=11 collides with INT.
        step(1, 2'd1, 4'hF, 32'd2, 32'd2, 0, "ar_pre");
        step(1, 2'd0, 4'hF, 32'hB, 32'hB, 0, "ar_wr");
        for (int k = 1; k <= 16; k++) begin
            wr = (k == 7) || (k == 11) || (k == 12);
            hi = (k == 6) || (k == 11) || (k == 16);
            step(wr, 2'd0, 4'hF, 32'hB, hi ? 32'h1B : 32'hB, hi, $sformatf("ar%0d", k));
        end
        step(1, 2'd0, 4'hF, 32'h0, 32'h0, 0, "ar_stop");

        // IM masked: PEND sets but irq stays low.
        step(1, 2'd1, 4'hF, 32'd1, 32'd1, 0, "im_pre");
        step(1, 2'd0, 4'hF, 32'h1, 32'h1, 0, "im_wr");
        for (int k = 1; k <= 6; k++) begin
            step(0, 2'd0, 4'h0, 0, (k >= 5) ? 32'h10 : 32'h1, 0, $sformatf("im%0d", k));
        end
        step(1, 2'd0, 4'hF, 32'h8, 32'h8, 0, "im_clr");

        // Disable at COUNT=7 so the frozen value is 6, then re-enable.
        step(1, 2'd1, 4'hF, 32'd10, 32'd10, 0, "dis_pre");
        step(1, 2'd0, 4'hF, 32'h1, 32'h1, 0, "dis_en");
        for (int k = 1; k <= 5; k++) begin
            exp_cnt = (k < 2) ? 0 : 12 - k;
            step(0, 2'd2, 4'h0, 0, 32'(exp_cnt), 0, $sformatf("dis_cnt%0d", k));
        end
        step(1, 2'd0, 4'hF, 32'h0, 32'h0, 0, "dis_off");
        for (int k = 7; k <= 9; k++) begin
            step(0, 2'd2, 4'h0, 0, 32'd6, 0, $sformatf("dis_hold%0d", k));
        end
        step(1, 2'd0, 4'hF, 32'h1, 32'h1, 0, "re_en");
        for (int j = 1; j <= 9; j++) begin
            exp_cnt = (j == 1) ? 6 : 12 - j;
            step((j == 4), 2'd2, 4'hF, 32'h0, 32'(exp_cnt), 0, $sformatf("re_cnt%0d", j));
        end

        // Reset in the middle of counting (COUNT=3).
        rst = 1'b0;
        step(0, 2'd2, 4'h0, 0, 32'h0, 0, "mr_cnt");
        step(0, 2'd1, 4'h0, 0, 32'h0, 0, "mr_pre");
        rst = 1'b1;
        step(0, 2'd0, 4'h0, 0, 32'h0, 0, "mr_ctrl");
        step(0, 2'd2, 4'h0, 0, 32'h0, 0, "mr_idle0");
        step(0, 2'd2, 4'h0, 0, 32'h0, 0, "mr_idle1");

        // PRESET written on the LOAD edge: COUNT still loads the old value.
        step(1, 2'd1, 4'hF, 32'd4, 32'd4, 0, "lc_pre");
        step(1, 2'd0, 4'hF, 32'h1, 32'h1, 0, "lc_en");
        step(0, 2'd2, 4'h0, 0, 32'd0, 0, "lc_k1");
        step(1, 2'd1, 4'hF, 32'd7, 32'd7, 0, "lc_pre2");
        step(0, 2'd2, 4'h0, 0, 32'd3, 0, "lc_k3");
        step(1, 2'd0, 4'hF, 32'h0, 32'h0, 0, "lc_off");

        // PRESET=0 one-shot; CTRL write of EN=1 on the INT edge loses to the EN clear.
        step(1, 2'd1, 4'hF, 32'd0, 32'd0, 0, "z_pre");
        step(1, 2'd0, 4'hF, 32'h1, 32'h1, 0, "z_en");
        for (int k = 1; k <= 3; k++) begin
            step(0, 2'd0, 4'h0, 0, 32'h1, 0, $sformatf("z%0d", k));
        end
        step(1, 2'd0, 4'hF, 32'h9, 32'h18, 1, "z_intwr");
        step(0, 2'd0, 4'h0, 0, 32'h18, 1, "z_after");
        step(0, 2'd2, 4'h0, 0, 32'h0, 1, "z_cnt");
        step(1, 2'd0, 4'hF, 32'h0, 32'h0, 0, "z_clr");

        we = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
